// File: rtl/ref_base_fetcher.sv
// Reference base fetcher: reads 32-bit words from memory port A and streams 2-bit bases MSB-first.
// Latency: first base_valid 3 cycles after start; then one base per cycle with prefetch, no bubbles.
// Backpressure: outputs hold while base_valid && !base_ready; shift register advances only on handshake.
// Optional feature macro: REF_COMPLEMENT_EN adds a 'complement' input that inverts every emitted base.
module ref_base_fetcher #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_WIDTH = 2,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  base_count,
`ifdef REF_COMPLEMENT_EN
  input  logic                  complement,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [BASE_WIDTH-1:0] base_out,
  output logic                  base_valid,
  input  logic                  base_ready,
  output logic                  base_last
);

  localparam int BPW  = DATA_WIDTH / BASE_WIDTH;
  localparam int IDXW = $clog2(BPW + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_STREAM, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_pf_buf;
  logic                  r_pf_full;
  logic                  r_pf_issued;
  logic                  r_valid;
  logic [IDXW-1:0]       r_idx;        // bases left in the shift register, including the presented one
  logic [LEN_WIDTH-1:0]  r_remain;     // bases left in the job, including the presented one
  logic [LEN_WIDTH-1:0]  r_words_left; // words not yet fetched beyond those already captured
  logic                  w_hs;
  logic                  w_last_hs;
  logic                  w_pf_issue;

  assign w_hs       = r_valid && base_ready;
  assign w_last_hs  = w_hs && (r_remain == LEN_WIDTH'(1));
  // The address register already points at the next word, so issuing is just flagging it.
  assign w_pf_issue = (r_state == S_STREAM) && (r_words_left != '0) && !r_pf_full && !r_pf_issued;

  assign mem_addr   = r_addr;
  assign base_valid = r_valid;
  assign base_last  = r_valid && (r_remain == LEN_WIDTH'(1));

`ifdef REF_COMPLEMENT_EN
  logic r_comp;

  // Complement selection is fixed for the whole job, captured with the start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comp <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_comp <= complement;
    end
  end

  assign base_out = r_shift[DATA_WIDTH-1 -: BASE_WIDTH] ^ {BASE_WIDTH{r_comp}};
`else
  assign base_out = r_shift[DATA_WIDTH-1 -: BASE_WIDTH];
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus busy/done status outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (base_count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy   = 1'b1;
        w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy   = 1'b1;
        w_next = S_STREAM;
      end
      S_STREAM: begin
        busy = 1'b1;
        if (w_last_hs) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: address generation, shift register, prefetch buffer and job counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_shift      <= '0;
      r_pf_buf     <= '0;
      r_pf_full    <= 1'b0;
      r_pf_issued  <= 1'b0;
      r_valid      <= 1'b0;
      r_idx        <= '0;
      r_remain     <= '0;
      r_words_left <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && base_count != '0) begin
            r_addr       <= start_addr & ~ADDR_WIDTH'(3);
            r_remain     <= base_count;
            r_words_left <= LEN_WIDTH'((base_count - 1'b1) / BPW);
            r_pf_full    <= 1'b0;
            r_pf_issued  <= 1'b0;
          end
        end
        S_CAPTURE: begin
          r_shift <= mem_rdata;
          r_valid <= 1'b1;
          r_idx   <= IDXW'(BPW);
          r_addr  <= r_addr + ADDR_WIDTH'(4);
        end
        S_STREAM: begin
          if (w_pf_issue) begin
            r_pf_issued <= 1'b1;
          end
          // Read data for the issued address arrives one cycle later.
          if (r_pf_issued) begin
            r_pf_buf     <= mem_rdata;
            r_pf_full    <= 1'b1;
            r_pf_issued  <= 1'b0;
            r_addr       <= r_addr + ADDR_WIDTH'(4);
            r_words_left <= r_words_left - 1'b1;
          end
          if (w_hs) begin
            r_remain <= r_remain - 1'b1;
            if (r_remain == LEN_WIDTH'(1)) begin
              r_valid <= 1'b0;
            end else if (r_idx == IDXW'(1)) begin
              // Word exhausted: swap in the prefetched word, or stall until it lands.
              if (r_pf_full) begin
                r_shift   <= r_pf_buf;
                r_idx     <= IDXW'(BPW);
                r_pf_full <= 1'b0;
              end else begin
                r_valid <= 1'b0;
              end
            end else begin
              r_shift <= r_shift << BASE_WIDTH;
              r_idx   <= r_idx - 1'b1;
            end
          end else if (!r_valid && r_pf_full) begin
            r_shift   <= r_pf_buf;
            r_idx     <= IDXW'(BPW);
            r_pf_full <= 1'b0;
            r_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ref_base_fetcher.sv
module tb_ref_base_fetcher;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] base_count;
  logic        complement;
  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [1:0]  base_out;
  logic        base_valid;
  logic        base_ready;
  logic        base_last;

  ref_base_fetcher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .base_count (base_count),
`ifdef REF_COMPLEMENT_EN
    .complement (complement),
`endif
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .base_out   (base_out),
    .base_valid (base_valid),
    .base_ready (base_ready),
    .base_last  (base_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model for port A.
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEADBEEF;

  typedef struct {
    logic [1:0] base;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic seen200 = 1'b0;
  logic prev_stall = 1'b0;
  logic [1:0] prev_base;
  logic prev_last;

  task automatic push(input logic [1:0] b, input logic last);
    exp_t e;
    e.base = b;
    e.last = last;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops and compares on every base handshake.
  always @(negedge clk) begin
    if (rst_n && base_valid && base_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_base: got base %0d last %0d with empty queue", base_out, base_last);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (base_out !== e.base || base_last !== e.last) begin
          errors++;
          $display("FAIL base_stream: got base %0d last %0d expected base %0d last %0d",
                   base_out, base_last, e.base, e.last);
        end
      end
    end
  end

  // Stall stability, done/busy exclusivity and forbidden-address watch.
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      checks++;
      if (base_valid !== 1'b1 || base_out !== prev_base || base_last !== prev_last) begin
        errors++;
        $display("FAIL stall_stable: got v%0d b%0d l%0d expected v1 b%0d l%0d",
                 base_valid, base_out, base_last, prev_base, prev_last);
      end
    end
    prev_stall = rst_n && base_valid && !base_ready;
    prev_base  = base_out;
    prev_last  = base_last;
    if (mem_addr == 32'h200) seen200 = 1'b1;
    if (rst_n && done) begin
      done_cnt++;
      chk("busy_low_with_done", {31'b0, busy}, 32'd0);
    end
  end

  // Runs one job. Cycle 0 is the start cycle; results are cycle indices relative to it.
  task automatic run_job(input logic [31:0] addr, input logic [15:0] cnt, input logic [63:0] pat,
                         input int rs_cyc, input int max_cyc,
                         output int done_cyc, output int first_v, output int vcnt,
                         output logic [31:0] addr1, output logic busy1);
    done_cyc = -1;
    first_v  = -1;
    vcnt     = 0;
    addr1    = '0;
    busy1    = 1'b0;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = addr;
    base_count = cnt;
    base_ready = pat[0];
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk); #1;
      start      = (k == rs_cyc);
      if (k == rs_cyc) begin
        start_addr = 32'h200;
        base_count = 16'd5;
      end
      base_ready = (k < 64) ? pat[k] : 1'b1;
      @(negedge clk);
      if (k == 1) begin
        addr1 = mem_addr;
        busy1 = busy;
      end
      if (base_valid) begin
        vcnt++;
        if (first_v < 0) first_v = k;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    @(posedge clk); #1;
    start      = 1'b0;
    base_ready = 1'b1;
  endtask

  int          dc, fv, vc;
  logic [31:0] a1;
  logic        b1;
  int          dsnap;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    base_count = '0;
    complement = 1'b0;
    base_ready = 1'b1;
    mem[32'h040] = 32'h1B1B1B1B;
    mem[32'h100] = 32'hFFFFFFFF;
    mem[32'h104] = 32'h00000000;
    mem[32'h108] = 32'h55555555;
    mem[32'h180] = 32'hE4000000;
    mem[32'h300] = 32'h0F0F0F0F;
    mem[32'h304] = 32'hAAAAAAAA;
    mem[32'h400] = 32'h1B1B1B1B;
    mem[32'h080] = 32'hE4E4E4E4;
    mem[32'h500] = 32'h1B000000;

    #12;
    chk("rst_busy",       {31'b0, busy},       32'd0);
    chk("rst_done",       {31'b0, done},       32'd0);
    chk("rst_mem_addr",   mem_addr,            32'd0);
    chk("rst_base_out",   {30'b0, base_out},   32'd0);
    chk("rst_base_valid", {31'b0, base_valid}, 32'd0);
    chk("rst_base_last",  {31'b0, base_last},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single full word.
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++) push(2'(b), (r == 3 && b == 3));
    run_job(32'h40, 16'd16, '1, -1, 100, dc, fv, vc, a1, b1);
    chk("t1_mem_addr", a1, 32'h40);
    chk("t1_busy",     {31'b0, b1}, 32'd1);
    chk("t1_first_v",  fv, 32'd3);
    chk("t1_done_cyc", dc, 32'd19);
    chk("t1_q_empty",  q.size(), 32'd0);

    // Multi-word, continuous ready, no bubbles.
    for (int i = 0; i < 48; i++) push((i < 16) ? 2'd3 : (i < 32) ? 2'd0 : 2'd1, i == 47);
    run_job(32'h100, 16'd48, '1, -1, 200, dc, fv, vc, a1, b1);
    chk("t2_mem_addr", a1, 32'h100);
    chk("t2_first_v",  fv, 32'd3);
    chk("t2_valid_cnt", vc, 32'd48);
    chk("t2_done_cyc", dc, 32'd51);
    chk("t2_q_empty",  q.size(), 32'd0);

    // Partial word, unaligned start address, backpressure 1,0,0,1,1 from the first valid cycle.
    push(2'd3, 1'b0);
    push(2'd2, 1'b0);
    push(2'd1, 1'b1);
    run_job(32'h183, 16'd3, 64'hFFFF_FFFF_FFFF_FFCF, -1, 100, dc, fv, vc, a1, b1);
    chk("t3_mem_addr",  a1, 32'h180);
    chk("t3_valid_cnt", vc, 32'd5);
    chk("t3_done_cyc",  dc, 32'd8);
    chk("t3_q_empty",   q.size(), 32'd0);

    // Empty job.
    dsnap = done_cnt;
    run_job(32'h40, 16'd0, '1, -1, 20, dc, fv, vc, a1, b1);
    chk("t4_done_cyc",  dc, 32'd1);
    chk("t4_valid_cnt", vc, 32'd0);
    chk("t4_done_cnt",  done_cnt - dsnap, 32'd1);

    // Start while busy is ignored.
    seen200 = 1'b0;
    for (int i = 0; i < 32; i++) push((i < 16) ? (((i % 4) < 2) ? 2'd0 : 2'd3) : 2'd2, i == 31);
    dsnap = done_cnt;
    run_job(32'h300, 16'd32, '1, 10, 200, dc, fv, vc, a1, b1);
    repeat (4) @(negedge clk);
    chk("t5_done_cyc",   dc, 32'd35);
    chk("t5_no_0x200",   {31'b0, seen200}, 32'd0);
    chk("t5_done_cnt",   done_cnt - dsnap, 32'd1);
    chk("t5_idle_busy",  {31'b0, busy}, 32'd0);
    chk("t5_q_empty",    q.size(), 32'd0);

    // Asynchronous reset while the 5th of 16 bases is presented.
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++) push(2'(b), (r == 3 && b == 3));
    dsnap = done_cnt;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = 32'h400;
    base_count = 16'd16;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2;
    chk("t6_pre_valid", {31'b0, base_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy",       {31'b0, busy},       32'd0);
    chk("t6_mem_addr",   mem_addr,            32'd0);
    chk("t6_base_valid", {31'b0, base_valid}, 32'd0);
    chk("t6_base_out",   {30'b0, base_out},   32'd0);
    chk("t6_base_last",  {31'b0, base_last},  32'd0);
    chk("t6_popped",     q.size(), 32'd12);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_no_done", done_cnt - dsnap, 32'd0);

    // Fresh job after reset.
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 4; b++) push(2'(3 - b), (r == 1 && b == 3));
    run_job(32'h80, 16'd8, '1, -1, 100, dc, fv, vc, a1, b1);
    chk("t7_mem_addr", a1, 32'h80);
    chk("t7_first_v",  fv, 32'd3);
    chk("t7_done_cyc", dc, 32'd11);
    chk("t7_q_empty",  q.size(), 32'd0);

`ifdef REF_COMPLEMENT_EN
    // Complemented output of 0x1B000000, four bases.
    complement = 1'b1;
    push(2'd3, 1'b0);
    push(2'd2, 1'b0);
    push(2'd1, 1'b0);
    push(2'd0, 1'b1);
    run_job(32'h500, 16'd4, '1, -1, 100, dc, fv, vc, a1, b1);
    complement = 1'b0;
    chk("t8_done_cyc", dc, 32'd7);
    chk("t8_q_empty",  q.size(), 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
